arf_err_stats: RTL and testbench
================================

# arf_err_stats

Streaming error-statistics collector that sits downstream of the approximate ARF datapath. It consumes pairs of (exact, approximate) filter outputs, one pair per handshake. Over a window of 2^LOG2_N samples it accumulates the signed error sum, the squared-error sum and the peak absolute error, then presents mean and variance. It is the read-out end of the approximate-unit variance experiments: the datapath produces samples, and this block measures them.

## Interface
- WIDTH, 16: signed sample width of `exact` / `approx`
- LOG2_N, 8: window length is N = 2^LOG2_N samples; legal range 1..16
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  starts a window; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- s_valid  in  1  sample pair valid
- s_ready  out  1  high only in ACCUM
- exact  in  WIDTH  signed exact result
- approx  in  WIDTH  signed approximate result
- m_valid  out  1  results valid; held until accepted
- m_ready  in  1  results accepted
- err_sum  out  WIDTH+1+LOG2_N  signed sum of e
- err_sq_sum  out  2*WIDTH+2+LOG2_N  unsigned sum of e*e
- err_mean  out  WIDTH+1  signed, err_sum >>> LOG2_N
- err_var  out  2*WIDTH+2  unsigned variance estimate
- err_max_abs  out  WIDTH+1  unsigned max |e|
- done  out  1  one-cycle pulse when results are accepted

## Operation
- e = approx − exact, sign-extended to WIDTH+1. It never overflows.
- States and transitions:
  - IDLE: start=1 → ACCUM. On that edge, clear all accumulators, the counter and err_max_abs.
  - ACCUM: on each s_valid & s_ready:
    - err_sum += e
    - err_sq_sum += e*e
    - err_max_abs = max(err_max_abs, |e|)
    - cnt += 1
    - A handshake with cnt == N−1 → MEAN.
  - MEAN: err_mean ← err_sum >>> LOG2_N (arithmetic shift, rounds toward −∞) → VAR.
  - VAR: err_var ← (err_sq_sum >> LOG2_N) − err_mean², clamped to 0 if negative. Set m_valid → HOLD.
  - HOLD: m_valid=1. On m_ready, clear m_valid, pulse done, go to IDLE.
- cnt is LOG2_N bits wide and wraps to 0 at the end of the window.
- Outputs keep their values after HOLD until the next start clears them.
- start outside IDLE is ignored. start and m_ready in the same HOLD cycle: m_ready is honoured, start is dropped.
- s_valid outside ACCUM: no handshake, and the data is ignored.
- Asynchronous reset at any point, including mid-window, aborts the window:
  - state IDLE
  - all outputs 0
  - s_ready=0, m_valid=0, done=0, busy=0

## Timing
- Reset values: every output 0.
- s_ready rises the cycle after start is sampled.
- There are no bubbles: with s_valid held high, one sample is accepted per clock, and the window takes exactly N cycles.
- Results latency: m_valid rises 2 cycles after the final sample's handshake edge (MEAN, then VAR).
- HOLD with m_ready already high lasts one cycle. done asserts in the cycle after m_ready is sampled, and busy is low in that same cycle.
- The minimum start-to-start period is N+4 cycles.
- All accumulator updates are registered and single-cycle. The e*e product and the mean² product are combinational and feed the register directly.

## Configuration
- ARF_ERR_MAX_EN
  - Defined: err_max_abs tracks the peak |e| of the window as described above.
  - Undefined: the |e| compare logic and register are not built, and err_max_abs is constant 0.
  - All other behaviour and timing are identical with or without the macro.

## Test plan
- Constant error (WIDTH=16, LOG2_N=2): four samples, exact=100, approx=103
  → err_sum=12, err_sq_sum=36, err_mean=3, err_var=0, err_max_abs=3; m_valid 2 cycles after the 4th handshake.
- Alternating error: e = +2, −2, +2, −2
  → err_sum=0, err_mean=0, err_sq_sum=16, err_var=4, err_max_abs=2.
- Extremes: exact=−32768, approx=32767 for all 4 samples
  → e=65535, err_sum=262140, err_sq_sum=4·65535², err_mean=65535, err_var=0; no wrap.
- Negative rounding: e = −1, 0, 0, 0
  → err_sum=−1, err_mean=−1, err_sq_sum=1, err_var = 0 − 1, clamped to 0.
- Handshake stress, checking that only handshaken samples count and done pulses once:
  - random s_valid gaps
  - m_ready held low for 10 cycles → m_valid and results stable throughout
  - start pulses during ACCUM/HOLD → ignored
- Reset mid-window: rst_n low after 2 of 4 samples → all outputs 0 immediately. A new start followed by 4 samples with e=1 → err_sum=4, with no residue from the aborted window.

Source files
------------

// File: rtl/arf_err_stats.sv
// Error-statistics collector for the approximate ARF datapath: sum, sum of squares,
// mean, variance and (with ARF_ERR_MAX_EN defined) peak |approx - exact| over 2^LOG2_N samples.
module arf_err_stats #(
    parameter int WIDTH  = 16,
    parameter int LOG2_N = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         start_i,
    output logic                         busy_o,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    input  logic [WIDTH-1:0]             exact_i,
    input  logic [WIDTH-1:0]             approx_i,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic [WIDTH+LOG2_N:0]        err_sum_o,
    output logic [2*WIDTH+1+LOG2_N:0]    err_sq_sum_o,
    output logic [WIDTH:0]               err_mean_o,
    output logic [2*WIDTH+1:0]           err_var_o,
    output logic [WIDTH:0]               err_max_abs_o,
    output logic                         done_o
);

    // state    | meaning
    // IDLE     | waiting for start
    // ACCUM    | accepting samples, s_ready high
    // MEAN     | registering err_sum >>> LOG2_N
    // VAR      | registering clamped variance
    // HOLD     | results valid until m_ready
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_MEAN,
        ST_VAR,
        ST_HOLD
    } state_e;

    localparam int EW = WIDTH + 1;
    localparam int SW = WIDTH + 1 + LOG2_N;
    localparam int QW = 2*WIDTH + 2 + LOG2_N;
    localparam int VW = 2*WIDTH + 2;

    state_e state_q, state_d;

    logic signed [SW-1:0] err_sum_q, err_sum_d;
    logic [QW-1:0]        err_sq_sum_q, err_sq_sum_d;
    logic signed [EW-1:0] err_mean_q, err_mean_d;
    logic [VW-1:0]        err_var_q, err_var_d;
    logic [LOG2_N-1:0]    cnt_q, cnt_d;
    logic                 m_valid_q, m_valid_d;
    logic                 done_q, done_d;

    logic signed [EW-1:0] exact_x, approx_x, e_s;
    logic [EW-1:0]        abs_e;
    logic [2*EW-1:0]      e_sq;
    logic                 s_hs;
    logic                 cnt_last;
    logic                 start_acc;
    logic [EW-1:0]        abs_mean;
    logic [VW-1:0]        mean_sq;
    logic [VW-1:0]        sq_shift;

    // Sign-extend by one bit so approx - exact can never overflow.
    assign exact_x  = {exact_i[WIDTH-1], exact_i};
    assign approx_x = {approx_i[WIDTH-1], approx_i};
    assign e_s      = approx_x - exact_x;
    assign abs_e    = e_s[EW-1] ? $unsigned(-e_s) : $unsigned(e_s);
    assign e_sq     = abs_e * abs_e;

    assign s_hs      = (state_q == ST_ACCUM) && s_valid_i;
    assign cnt_last  = &cnt_q;
    assign start_acc = (state_q == ST_IDLE) && start_i;

    assign abs_mean = err_mean_q[EW-1] ? $unsigned(-err_mean_q) : $unsigned(err_mean_q);
    assign mean_sq  = abs_mean * abs_mean;
    assign sq_shift = VW'(err_sq_sum_q >> LOG2_N);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_ACCUM;
            ST_ACCUM: if (s_valid_i && cnt_last) state_d = ST_MEAN;
            ST_MEAN:  state_d = ST_VAR;
            ST_VAR:   state_d = ST_HOLD;
            ST_HOLD:  if (m_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_sum_d    = err_sum_q;
        err_sq_sum_d = err_sq_sum_q;
        err_mean_d   = err_mean_q;
        err_var_d    = err_var_q;
        cnt_d        = cnt_q;
        m_valid_d    = m_valid_q;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    err_sum_d    = '0;
                    err_sq_sum_d = '0;
                    err_mean_d   = '0;
                    err_var_d    = '0;
                    cnt_d        = '0;
                end
            end
            ST_ACCUM: begin
                if (s_valid_i) begin
                    err_sum_d    = err_sum_q + SW'(e_s);
                    err_sq_sum_d = err_sq_sum_q + QW'(e_sq);
                    cnt_d        = cnt_q + LOG2_N'(1);
                end
            end
            ST_MEAN: begin
                err_mean_d = EW'(err_sum_q >>> LOG2_N);
            end
            ST_VAR: begin
                // Finite-precision mean can make mean^2 exceed E[e^2]; clamp to 0.
                err_var_d = (sq_shift >= mean_sq) ? (sq_shift - mean_sq) : '0;
                m_valid_d = 1'b1;
            end
            ST_HOLD: begin
                if (m_ready_i) begin
                    m_valid_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            err_sum_q    <= '0;
            err_sq_sum_q <= '0;
            err_mean_q   <= '0;
            err_var_q    <= '0;
            cnt_q        <= '0;
            m_valid_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_sum_q    <= err_sum_d;
            err_sq_sum_q <= err_sq_sum_d;
            err_mean_q   <= err_mean_d;
            err_var_q    <= err_var_d;
            cnt_q        <= cnt_d;
            m_valid_q    <= m_valid_d;
            done_q       <= done_d;
        end
    end

`ifdef ARF_ERR_MAX_EN
    logic [EW-1:0] max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (start_acc) begin
            max_d = '0;
        end else if (s_hs && (abs_e > max_q)) begin
            max_d = abs_e;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign err_max_abs_o = max_q;
`else
    logic unused_max;
    assign unused_max    = start_acc ^ s_hs;
    assign err_max_abs_o = '0;
`endif

    assign busy_o       = (state_q != ST_IDLE);
    assign s_ready_o    = (state_q == ST_ACCUM);
    assign m_valid_o    = m_valid_q;
    assign done_o       = done_q;
    assign err_sum_o    = err_sum_q;
    assign err_sq_sum_o = err_sq_sum_q;
    assign err_mean_o   = err_mean_q;
    assign err_var_o    = err_var_q;

endmodule

// File: tb/tb_arf_err_stats.sv
// Directed bench for arf_err_stats (WIDTH=16, LOG2_N=2); peak-|e| expectations follow ARF_ERR_MAX_EN.
module tb_arf_err_stats;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic        busy_o;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [15:0] exact_i;
    logic [15:0] approx_i;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [18:0] err_sum_o;
    logic [35:0] err_sq_sum_o;
    logic [16:0] err_mean_o;
    logic [33:0] err_var_o;
    logic [16:0] err_max_abs_o;
    logic        done_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] ex_v [4];
    logic [15:0] ap_v [4];

    arf_err_stats #(.WIDTH(16), .LOG2_N(2)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .start_i       (start_i),
        .busy_o        (busy_o),
        .s_valid_i     (s_valid_i),
        .s_ready_o     (s_ready_o),
        .exact_i       (exact_i),
        .approx_i      (approx_i),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .err_sum_o     (err_sum_o),
        .err_sq_sum_o  (err_sq_sum_o),
        .err_mean_o    (err_mean_o),
        .err_var_o     (err_var_o),
        .err_max_abs_o (err_max_abs_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [16:0] exp_max(input logic [16:0] v);
`ifdef ARF_ERR_MAX_EN
        return v;
`else
        return v & 17'h0;
`endif
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_zero_outputs(input string nm);
        check_val({nm, "_sum"},    64'(err_sum_o), 64'd0);
        check_val({nm, "_sq"},     64'(err_sq_sum_o), 64'd0);
        check_val({nm, "_mean"},   64'(err_mean_o), 64'd0);
        check_val({nm, "_var"},    64'(err_var_o), 64'd0);
        check_val({nm, "_max"},    64'(err_max_abs_o), 64'd0);
        check_val({nm, "_busy"},   64'(busy_o), 64'd0);
        check_val({nm, "_sready"}, 64'(s_ready_o), 64'd0);
        check_val({nm, "_mvalid"}, 64'(m_valid_o), 64'd0);
        check_val({nm, "_done"},   64'(done_o), 64'd0);
    endtask

    task automatic run_window(input string nm, input bit gaps, input int hold_cyc,
                              input logic [18:0] e_sum, input logic [35:0] e_sq,
                              input logic [16:0] e_mean, input logic [33:0] e_var,
                              input logic [16:0] e_max);
        int idx;
        int guard;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check_val({nm, "_sready_rise"}, 64'(s_ready_o), 64'd1);
        check_val({nm, "_busy"},        64'(busy_o), 64'd1);
        idx   = 0;
        guard = 0;
        while (idx < 4 && guard < 100) begin
            s_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            start_i   = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            exact_i   = s_valid_i ? ex_v[idx] : 16'($urandom);
            approx_i  = s_valid_i ? ap_v[idx] : 16'($urandom);
            step();
            if (s_valid_i) idx++;
            guard++;
        end
        check_val({nm, "_samples"}, 64'(idx), 64'd4);
        // Garbage offered outside ACCUM must be ignored.
        start_i   = 1'b0;
        s_valid_i = gaps;
        exact_i   = 16'($urandom);
        approx_i  = 16'($urandom);
        check_val({nm, "_mvalid_mean"}, 64'(m_valid_o), 64'd0);
        check_val({nm, "_sready_off"},  64'(s_ready_o), 64'd0);
        step();
        check_val({nm, "_mvalid_var"}, 64'(m_valid_o), 64'd0);
        step();
        check_val({nm, "_mvalid_hold"}, 64'(m_valid_o), 64'd1);
        for (int c = 0; c < hold_cyc; c++) begin
            start_i = 1'($urandom_range(0, 1));
            step();
            check_val({nm, "_hold_mvalid"}, 64'(m_valid_o), 64'd1);
            check_val({nm, "_hold_sum"},    64'(err_sum_o), 64'(e_sum));
            check_val({nm, "_hold_done"},   64'(done_o), 64'd0);
        end
        m_ready_i = 1'b1;
        start_i   = gaps;
        step();
        m_ready_i = 1'b0;
        start_i   = 1'b0;
        s_valid_i = 1'b0;
        check_val({nm, "_done"},   64'(done_o), 64'd1);
        check_val({nm, "_busy_done"}, 64'(busy_o), 64'd0);
        check_val({nm, "_mvalid_clr"}, 64'(m_valid_o), 64'd0);
        check_val({nm, "_sum"},    64'(err_sum_o), 64'(e_sum));
        check_val({nm, "_sq"},     64'(err_sq_sum_o), 64'(e_sq));
        check_val({nm, "_mean"},   64'(err_mean_o), 64'(e_mean));
        check_val({nm, "_var"},    64'(err_var_o), 64'(e_var));
        check_val({nm, "_max"},    64'(err_max_abs_o), 64'(exp_max(e_max)));
        step();
        check_val({nm, "_done_once"}, 64'(done_o), 64'd0);
        check_val({nm, "_idle"},      64'(busy_o), 64'd0);
        check_val({nm, "_keep_sum"},  64'(err_sum_o), 64'(e_sum));
    endtask

    task automatic set_vec(input logic [15:0] ex, input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] a2, input logic [15:0] a3);
        for (int i = 0; i < 4; i++) ex_v[i] = ex;
        ap_v[0] = a0;
        ap_v[1] = a1;
        ap_v[2] = a2;
        ap_v[3] = a3;
    endtask

    initial begin
        rst_n_i   = 1'b0;
        start_i   = 1'b0;
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
        exact_i   = '0;
        approx_i  = '0;
        step();
        step();
        check_zero_outputs("reset");
        rst_n_i = 1'b1;
        step();
        check_val("post_reset_busy", 64'(busy_o), 64'd0);

        // Constant error +3
        set_vec(16'd100, 16'd103, 16'd103, 16'd103, 16'd103);
        run_window("const", 1'b0, 0, 19'd12, 36'd36, 17'd3, 34'd0, 17'd3);

        // Alternating +2/-2
        set_vec(16'd0, 16'd2, 16'hFFFE, 16'd2, 16'hFFFE);
        run_window("alt", 1'b0, 0, 19'd0, 36'd16, 17'd0, 34'd4, 17'd2);

        // Extremes: e = 65535 every sample
        set_vec(16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_window("ext", 1'b0, 0, 19'h3FFFC, 36'h3FFF80004, 17'h0FFFF, 34'd0, 17'h0FFFF);

        // Negative rounding: e = -1,0,0,0
        set_vec(16'd0, 16'hFFFF, 16'd0, 16'd0, 16'd0);
        run_window("negrnd", 1'b0, 0, 19'h7FFFF, 36'd1, 17'h1FFFF, 34'd0, 17'd1);

        // Handshake stress: e = 5,-3,7,-1 with gaps, stray starts, 10-cycle hold
        set_vec(16'd0, 16'd5, 16'hFFFD, 16'd7, 16'hFFFF);
        run_window("stress", 1'b1, 10, 19'd8, 36'd84, 17'd2, 34'd17, 17'd7);

        // Reset mid-window after 2 samples of e=5
        start_i = 1'b1;
        step();
        start_i   = 1'b0;
        s_valid_i = 1'b1;
        exact_i   = 16'd0;
        approx_i  = 16'd5;
        step();
        step();
        s_valid_i = 1'b0;
        check_val("midwin_sum", 64'(err_sum_o), 64'd10);
        rst_n_i = 1'b0;
        #1;
        check_zero_outputs("abort");
        step();
        rst_n_i = 1'b1;
        step();

        set_vec(16'd10, 16'd11, 16'd11, 16'd11, 16'd11);
        run_window("after_abort", 1'b0, 0, 19'd4, 36'd4, 17'd1, 34'd0, 17'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
